// File: rtl/dff_rst.sv
//------------------------------------------------------------------------------
// Module     : dff_rst
// Description: Positive-edge D flip-flop with synchronous, active-high reset.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dff_rst #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Reset wins over d; the decision is only ever sampled at the clock edge.
  always_comb begin
    q_d = d;
    if (reset) begin
      q_d = RESET_VALUE;
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_rst.sv
//------------------------------------------------------------------------------
// Module     : tb_dff_rst
// Description: Scoreboard bench for dff_rst, default and 8-bit/A5 instances.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dff_rst;

  localparam logic [7:0] C_RV8 = 8'hA5;

  logic       clock = 1'b0;
  logic       reset;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;

  always #5 clock = ~clock;

  dff_rst u_dut1 (
    .clock (clock),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  dff_rst #(
    .WIDTH       (8),
    .RESET_VALUE (C_RV8)
  ) u_dut8 (
    .clock (clock),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  typedef struct {
    string      tag;
    logic       exp1;
    logic [7:0] exp8;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       last1;
  logic [7:0] last8;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive at the falling edge and record what the next rising edge must produce.
  task automatic drive(input string tag, input logic r, input logic v1, input logic [7:0] v8);
    @(negedge clock);
    reset = r;
    d1    = v1;
    d8    = v8;
    sb.push_back('{tag, r ? 1'b0 : v1, r ? C_RV8 : v8});
  endtask

  task automatic edge_check();
    exp_t e;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_w1"}, {7'd0, q1}, {7'd0, e.exp1});
      check({e.tag, "_w8"}, q8, e.exp8);
      last1 = e.exp1;
      last8 = e.exp8;
    end
  endtask

  // Between edges the outputs must still show what the previous edge loaded.
  task automatic mid_check(input string tag);
    #2;
    check({tag, "_mid_w1"}, {7'd0, q1}, {7'd0, last1});
    check({tag, "_mid_w8"}, q8, last8);
  endtask

  initial begin
    reset = 1'b1;
    d1    = 1'b1;
    d8    = 8'hFF;

    // Reset with d high, then held for three edges with d toggling
    drive("rst0", 1'b1, 1'b1, 8'hFF);
    edge_check();
    for (int i = 0; i < 3; i++) begin
      drive("rst_hold", 1'b1, i[0], 8'h5A ^ 8'(i));
      edge_check();
    end

    // Capture 1, 0, 1
    drive("cap1", 1'b0, 1'b1, 8'h3C);
    edge_check();
    drive("cap2", 1'b0, 1'b0, 8'hC3);
    edge_check();
    drive("cap3", 1'b0, 1'b1, 8'h3C);
    edge_check();

    // Reset raised between edges: no effect until the next rising edge
    drive("sync", 1'b1, 1'b1, 8'h3C);
    mid_check("sync");
    edge_check();

    // Reset released between edges: first low-sampling edge loads d
    drive("rel", 1'b0, 1'b1, 8'h5A);
    mid_check("rel");
    edge_check();

    // d pulse entirely between two edges leaves q untouched
    drive("imm_pre", 1'b0, 1'b0, 8'h00);
    edge_check();
    @(negedge clock);
    d1 = 1'b1;
    d8 = 8'hFF;
    #1;
    d1 = 1'b0;
    d8 = 8'h00;
    #1;
    check("imm_mid_w1", {7'd0, q1}, 8'h00);
    check("imm_mid_w8", q8, 8'h00);
    sb.push_back('{"imm", 1'b0, 8'h00});
    edge_check();

    // Mixed random traffic with occasional reset
    for (int i = 0; i < 24; i++) begin
      drive("rand", ($urandom_range(0, 4) == 0), 1'($urandom), 8'($urandom));
      edge_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
